// File: rtl/mm_result_reader.sv
// mm_result_reader
// ----------------
// Drains the matrix-multiply core's result RAM after the core raises `mm_finish`.
// Each result slot is read through a single read request. The core then returns
// the 18-bit result as two 9-bit halves on consecutive cycles, lower half first.
// The halves are reassembled and offered on a valid/ready stream, together with
// the slot index and a last-flag.
//
// Only one read is outstanding at any time. The next slot is requested only after
// the previous result has been accepted, so the core's read timing never reaches
// the consumer.
//
// Parameters:
//   NUM_SLOTS   number of slots drained per run (1..32), read in ascending order
//   READ_LAT    cycles from the mm_read pulse to the lower half on mm_out_data (>=1)
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   mm_finish    core finish flag (level); a drain starts on its rising edge
//   mm_read      one-cycle read request to the core
//   mm_ram_slot  slot address; valid while mm_read=1, otherwise 0
//   mm_out_data  core read data: lower half, then upper half on the next cycle
//   res_data     reassembled result {upper, lower}
//   res_idx      slot index of res_data
//   res_last     high with the final slot's result
//   res_valid    result available
//   res_ready    consumer accepts when res_valid & res_ready
//   busy         drain in progress (every state except idle)
//   done         one-cycle pulse after the last result has been accepted
//   checksum     (only with MM_READER_CHECKSUM_EN) running sum of accepted
//                results, mod 2^24; cleared on each trigger edge
//
// Optional feature macro: MM_READER_CHECKSUM_EN

module mm_result_reader #(
  parameter int unsigned NUM_SLOTS = 16,
  parameter int unsigned READ_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mm_finish,
  output logic        mm_read,
  output logic [4:0]  mm_ram_slot,
  input  logic [8:0]  mm_out_data,
  output logic [17:0] res_data,
  output logic [4:0]  res_idx,
  output logic        res_last,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        done
`ifdef MM_READER_CHECKSUM_EN
  ,
  output logic [23:0] checksum
`endif
);

  // The latency counter holds READ_LAT-1 at most.
  localparam int unsigned LatW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [LatW-1:0] LatInit = LatW'(READ_LAT - 1);
  localparam logic [LatW-1:0] LatOne  = LatW'(1);
  localparam logic [4:0] LastSlot = 5'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCapLo,
    StCapHi,
    StPush,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic            finish_q;
  logic [4:0]      slot_q, slot_d;
  logic [LatW-1:0] lat_q, lat_d;
  logic [8:0]      lo_q;
  logic [17:0]     res_data_q;
  logic [4:0]      res_idx_q;
  logic            res_last_q;
  logic            valid_q;

  logic trigger;
  logic handshake;
  logic cap_lo;
  logic cap_hi;

  // Edge detect on the level flag; a held level cannot retrigger.
  assign trigger   = mm_finish & ~finish_q;
  assign handshake = valid_q & res_ready;

  // Next-state and decoded outputs
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    lat_d       = lat_q;
    mm_read     = 1'b0;
    mm_ram_slot = 5'd0;
    done        = 1'b0;
    cap_lo      = 1'b0;
    cap_hi      = 1'b0;

    case (state_q)
      StIdle: begin
        if (trigger) begin
          slot_d  = 5'd0;
          state_d = StIssue;
        end
      end

      StIssue: begin
        mm_read     = 1'b1;
        mm_ram_slot = slot_q;
        lat_d       = LatInit;
        state_d     = (READ_LAT == 1) ? StCapLo : StWait;
      end

      // Leaving when the counter reads 1 places StCapLo exactly READ_LAT cycles
      // after StIssue.
      StWait: begin
        lat_d = lat_q - LatOne;
        if (lat_q == LatOne) begin
          state_d = StCapLo;
        end
      end

      StCapLo: begin
        cap_lo  = 1'b1;
        state_d = StCapHi;
      end

      StCapHi: begin
        cap_hi  = 1'b1;
        state_d = StPush;
      end

      StPush: begin
        if (handshake) begin
          if (res_last_q) begin
            state_d = StDone;
          end else begin
            slot_d  = slot_q + 5'd1;
            state_d = StIssue;
          end
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      finish_q   <= 1'b0;
      slot_q     <= 5'd0;
      lat_q      <= '0;
      lo_q       <= 9'd0;
      res_data_q <= 18'd0;
      res_idx_q  <= 5'd0;
      res_last_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      finish_q <= mm_finish;
      slot_q   <= slot_d;
      lat_q    <= lat_d;
      if (cap_lo) begin
        lo_q <= mm_out_data;
      end
      // The upper half arrives in the cycle after the lower half, so it is
      // merged straight into the output register.
      if (cap_hi) begin
        res_data_q <= {mm_out_data, lo_q};
        res_idx_q  <= slot_q;
        res_last_q <= (slot_q == LastSlot);
        valid_q    <= 1'b1;
      end else if (handshake) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef MM_READER_CHECKSUM_EN
  logic [23:0] checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= 24'd0;
    end else if ((state_q == StIdle) && trigger) begin
      checksum_q <= 24'd0;
    end else if (handshake) begin
      checksum_q <= checksum_q + {6'd0, res_data_q};
    end
  end

  assign checksum = checksum_q;
`endif

  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;
  assign res_last  = res_last_q;
  assign res_valid = valid_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mm_result_reader.sv
`timescale 1ns/1ps
module tb_mm_result_reader;

  localparam int NumSlots = 4;
  localparam int ReadLat  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mm_finish = 1'b0;
  logic        mm_read;
  logic [4:0]  mm_ram_slot;
  logic [8:0]  mm_out_data = 9'd0;
  logic [17:0] res_data;
  logic [4:0]  res_idx;
  logic        res_last;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        busy;
  logic        done;
`ifdef MM_READER_CHECKSUM_EN
  logic [23:0] checksum;
`endif

  mm_result_reader #(
    .NUM_SLOTS (NumSlots),
    .READ_LAT  (ReadLat)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mm_finish   (mm_finish),
    .mm_read     (mm_read),
    .mm_ram_slot (mm_ram_slot),
    .mm_out_data (mm_out_data),
    .res_data    (res_data),
    .res_idx     (res_idx),
    .res_last    (res_last),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy),
    .done        (done)
`ifdef MM_READER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  idx;
    logic [17:0] data;
    logic        last;
  } res_t;

  res_t        exp_q[$];
  res_t        mon_e;
  logic [17:0] mem [32];
  logic [23:0] csum_exp;
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          issue_cyc = -100;
  logic [4:0]  issue_slot = 5'd0;
  int          issue_due_cyc = -1;
  int          done_due_cyc = -1;
  int          ready_mode = 0;
  int          stall_cnt = 0;

  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;
  logic        prev_read = 1'b0;
  logic [17:0] prev_data = 18'd0;
  logic [4:0]  prev_idx = 5'd0;
  logic        prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Core model: one read in flight; lower half READ_LAT cycles after the
  // request, upper half one cycle later, garbage on every other cycle.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == issue_cyc + ReadLat) mm_out_data = mem[issue_slot][8:0];
      else if (cyc == issue_cyc + ReadLat + 1) mm_out_data = mem[issue_slot][17:9];
      else mm_out_data = 9'($urandom);
    end
  end

  // Consumer ready generator
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: res_ready = 1'b1;
        1: res_ready = 1'($urandom_range(0, 1));
        2: begin
          if (res_valid && res_idx == 5'd1 && stall_cnt < 10) begin
            res_ready = 1'b0;
            stall_cnt++;
          end else begin
            res_ready = 1'b1;
          end
        end
        3: res_ready = !(res_valid && res_idx == 5'd2);
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid    = 1'b0;
      prev_hs       = 1'b0;
      prev_read     = 1'b0;
      issue_due_cyc = -1;
      done_due_cyc  = -1;
    end else begin
      if (mm_read) begin
        chk("read_back_to_back", {31'd0, prev_read}, 32'd0);
        chk("read_while_valid", {31'd0, res_valid}, 32'd0);
        if (exp_q.size() == 0) chk("read_unexpected", {31'd0, mm_read}, 32'd0);
        else chk("read_slot", {27'd0, mm_ram_slot}, {27'd0, exp_q[0].idx});
        if (issue_due_cyc >= 0) chk("read_timing", cyc, issue_due_cyc);
        issue_due_cyc = -1;
        issue_cyc     = cyc;
        issue_slot    = mm_ram_slot;
      end else if (mm_ram_slot != 5'd0) begin
        chk("slot_idle_zero", {27'd0, mm_ram_slot}, 32'd0);
      end

      if (res_valid && !prev_valid) chk("valid_latency", cyc, issue_cyc + ReadLat + 2);

      if (prev_valid && !prev_hs) begin
        chk("stall_valid", {31'd0, res_valid}, 32'd1);
        chk("stall_data", {14'd0, res_data}, {14'd0, prev_data});
        chk("stall_idx", {27'd0, res_idx}, {27'd0, prev_idx});
        chk("stall_last", {31'd0, res_last}, {31'd0, prev_last});
      end

      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("result_unexpected", {31'd0, res_valid}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("res_idx", {27'd0, res_idx}, {27'd0, mon_e.idx});
          chk("res_data", {14'd0, res_data}, {14'd0, mon_e.data});
          chk("res_last", {31'd0, res_last}, {31'd0, mon_e.last});
          if (mon_e.last) done_due_cyc = cyc + 1;
          else issue_due_cyc = cyc + 1;
        end
      end

      if (cyc == done_due_cyc) begin
        chk("done_pulse", {31'd0, done}, 32'd1);
        done_due_cyc = -1;
      end else if (done) begin
        chk("done_unexpected", {31'd0, done}, 32'd0);
      end

      prev_valid = res_valid;
      prev_hs    = res_valid & res_ready;
      prev_read  = mm_read;
      prev_data  = res_data;
      prev_idx   = res_idx;
      prev_last  = res_last;
    end
  end

  task automatic fill(input int mode);
    for (int k = 0; k < NumSlots; k++) begin
      case (mode)
        0: mem[k] = 18'(k * 1000 + 7);
        1: mem[k] = 18'($urandom);
        2: mem[k] = 18'h003FF;  // lo 9'h1FF, hi 9'h001
        3: mem[k] = 18'h3FFFF;
        default: mem[k] = 18'd0;
      endcase
    end
  endtask

  task automatic expect_drain();
    res_t e;
    csum_exp = 24'd0;
    for (int k = 0; k < NumSlots; k++) begin
      e.idx  = 5'(k);
      e.data = mem[k];
      e.last = (k == NumSlots - 1);
      exp_q.push_back(e);
      csum_exp = csum_exp + {6'd0, mem[k]};
    end
  endtask

  task automatic start_drain();
    expect_drain();
    @(posedge clk);
    #1;
    mm_finish     = 1'b1;
    issue_due_cyc = cyc + 1;
  endtask

  task automatic drop_finish();
    @(posedge clk);
    #1;
    mm_finish = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < 500);
    chk("drain_complete", exp_q.size(), 32'd0);
    exp_q.delete();
    @(negedge clk);
    chk("idle_after_drain", {31'd0, busy}, 32'd0);
`ifdef MM_READER_CHECKSUM_EN
    chk("checksum", {8'd0, checksum}, {8'd0, csum_exp});
`endif
  endtask

  initial begin
    int n;
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_mm_read", {31'd0, mm_read}, 32'd0);
    chk("rst_slot", {27'd0, mm_ram_slot}, 32'd0);
    chk("rst_res_data", {14'd0, res_data}, 32'd0);
    chk("rst_res_idx", {27'd0, res_idx}, 32'd0);
    chk("rst_res_last", {31'd0, res_last}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
`ifdef MM_READER_CHECKSUM_EN
    chk("rst_checksum", {8'd0, checksum}, 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic drain, ready tied high
    ready_mode = 0;
    fill(0);
    start_drain();
    wait_drain();
    drop_finish();

    // Half ordering
    fill(2);
    start_drain();
    wait_drain();
    drop_finish();

    // Backpressure on slot 1
    ready_mode = 2;
    stall_cnt  = 0;
    fill(1);
    start_drain();
    wait_drain();
    chk("stall_cycles", stall_cnt, 32'd10);
    drop_finish();

    // Random data with random backpressure
    ready_mode = 1;
    for (int r = 0; r < 4; r++) begin
      fill(1);
      start_drain();
      wait_drain();
      drop_finish();
    end

    // Held level: one drain only
    ready_mode = 0;
    fill(1);
    start_drain();
    wait_drain();
    repeat (30) @(posedge clk);
    drop_finish();
    // Re-raise: second drain from slot 0
    fill(0);
    start_drain();
    wait_drain();
    drop_finish();
    // Pulse mid-drain is ignored
    fill(1);
    start_drain();
    repeat (2) @(posedge clk);
    #1 mm_finish = 1'b0;
    repeat (2) @(posedge clk);
    #1 mm_finish = 1'b1;
    @(posedge clk);
    #1 mm_finish = 1'b0;
    wait_drain();
    repeat (30) @(posedge clk);

    // Checksum patterns: all-ones then zeros
    fill(3);
    start_drain();
    wait_drain();
    drop_finish();
    fill(4);
    start_drain();
    wait_drain();
    drop_finish();

    // Reset while slot 2 waits in the push state
    ready_mode = 3;
    fill(0);
    start_drain();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(res_valid && res_idx == 5'd2) && n < 200);
    chk("reach_slot2_push", {27'd0, res_idx}, 32'd2);
    #1;
    rst_n     = 1'b0;
    mm_finish = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_read", {31'd0, mm_read}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    ready_mode = 0;
    fill(1);
    start_drain();
    wait_drain();
    drop_finish();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
